// File: rtl/pixel_phase_tracker.sv
// Pixel-rate enable generator: divides the fast PLL clock by RATIO and keeps the divider
// aligned to a synchronised copy of the incoming pixel clock, reporting lock and slips.
module pixel_phase_tracker #(
  parameter int RATIO       = 6,
  parameter int CNT_W       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int JITTER_TOL  = 0,
  parameter int LOCK_COUNT  = 16,
  parameter int LOSS_CYCLES = 24
) (
  input  logic             pixelClockXn,
  input  logic             nReset,
  input  logic             pixelClockRef,
  input  logic             trackEnable,
  input  logic [CNT_W-1:0] phaseSelect,
  output logic             pixelClockX1_en,
  output logic [CNT_W-1:0] currentPhase,
  output logic             locked,
  output logic [7:0]       slipCount
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int LOSS_W  = $clog2(LOSS_CYCLES + 1);

  localparam logic [CNT_W-1:0]   LAST_PHASE = CNT_W'(RATIO - 1);
  localparam logic [CNT_W-1:0]   TOL_LO     = CNT_W'(JITTER_TOL);
  localparam logic [CNT_W-1:0]   TOL_HI     = CNT_W'(RATIO - JITTER_TOL);
  localparam logic [CNT_W-1:0]   MIN_SPACE  = CNT_W'(RATIO / 2);
  localparam logic [MATCH_W-1:0] MATCH_MAX  = MATCH_W'(LOCK_COUNT);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [LOSS_W-1:0]  LOSS_MAX   = LOSS_W'(LOSS_CYCLES);
  localparam logic [LOSS_W-1:0]  LOSS_LAST  = LOSS_W'(LOSS_CYCLES - 1);

  logic [SYNC_STAGES-1:0] refSync_p0;
  logic                   refSyncD_p1;
  logic                   refRise;
  logic [MATCH_W-1:0]     matchCnt;
  logic [LOSS_W-1:0]      lossTimer;
  logic [CNT_W-1:0]       spaceCnt;
  logic [CNT_W-1:0]       effPhase;
  logic                   inTol;
  logic                   slip;
  logic                   fire;

  function automatic logic [7:0] satIncSlip(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [MATCH_W-1:0] satIncMatch(input logic [MATCH_W-1:0] v);
    return (v >= MATCH_MAX) ? MATCH_MAX : v + MATCH_W'(1);
  endfunction

  function automatic logic [LOSS_W-1:0] satIncLoss(input logic [LOSS_W-1:0] v);
    return (v >= LOSS_MAX) ? LOSS_MAX : v + LOSS_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] satIncSpace(input logic [CNT_W-1:0] v);
    return (v >= MIN_SPACE) ? MIN_SPACE : v + CNT_W'(1);
  endfunction

  // Upper tolerance band only exists when JITTER_TOL > 0; otherwise TOL_HI may alias to 0.
  function automatic logic phaseInTol(input logic [CNT_W-1:0] p);
    return (p <= TOL_LO) || ((JITTER_TOL > 0) && (p >= TOL_HI));
  endfunction

  assign refRise  = refSync_p0[SYNC_STAGES-1] & ~refSyncD_p1;
  assign inTol    = phaseInTol(currentPhase);
  assign slip     = refRise & trackEnable & ~inTol;
  assign effPhase = (phaseSelect > LAST_PHASE) ? LAST_PHASE : phaseSelect;
  assign fire     = (currentPhase == effPhase) && (spaceCnt >= MIN_SPACE);

  always_ff @(posedge pixelClockXn) begin
    if (!nReset) begin
      refSync_p0      <= '0;
      refSyncD_p1     <= 1'b0;
      currentPhase    <= '0;
      pixelClockX1_en <= 1'b0;
      spaceCnt        <= '0;
      slipCount       <= '0;
      matchCnt        <= '0;
      lossTimer       <= '0;
      locked          <= 1'b0;
    end else begin
      // p0: synchroniser, p1: delayed copy for edge detect
      refSync_p0  <= {refSync_p0[SYNC_STAGES-2:0], pixelClockRef};
      refSyncD_p1 <= refSync_p0[SYNC_STAGES-1];

      if (slip)
        currentPhase <= CNT_W'(1);
      else if (currentPhase == LAST_PHASE)
        currentPhase <= '0;
      else
        currentPhase <= currentPhase + CNT_W'(1);

      // compare always sees the pre-reload phase, so a slip never steals this cycle's pulse
      pixelClockX1_en <= fire;
      spaceCnt        <= fire ? CNT_W'(1) : satIncSpace(spaceCnt);

      if (slip)
        slipCount <= satIncSlip(slipCount);

      if (refRise) begin
        lossTimer <= '0;
        if (inTol) begin
          matchCnt <= satIncMatch(matchCnt);
          if (matchCnt >= MATCH_LAST)
            locked <= 1'b1;
        end else begin
          matchCnt <= '0;
          locked   <= 1'b0;
        end
      end else begin
        lossTimer <= satIncLoss(lossTimer);
        if (lossTimer >= LOSS_LAST) begin
          locked   <= 1'b0;
          matchCnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_phase_tracker.sv
// Directed bench for pixel_phase_tracker: free-run, alignment/lock, slip and relock,
// jitter tolerance, reference loss, phase clamp, spacing guard, reset and slip saturation.
module tb_pixel_phase_tracker;

  logic       clk = 1'b0;
  logic       nReset;
  logic       refA;
  logic       refJ;
  logic       trackEnable;
  logic [2:0] phaseSelect;
  logic       enA, enJ, lockA, lockJ;
  logic [2:0] phA, phJ;
  logic [7:0] slipA, slipJ;

  int nVec = 0;
  int nMis = 0;
  int sinceEn = 100;
  bit gapBad = 1'b0;

  always #5 clk = ~clk;

  pixel_phase_tracker dut (
    .pixelClockXn(clk), .nReset(nReset), .pixelClockRef(refA), .trackEnable(trackEnable),
    .phaseSelect(phaseSelect), .pixelClockX1_en(enA), .currentPhase(phA),
    .locked(lockA), .slipCount(slipA)
  );

  pixel_phase_tracker #(.JITTER_TOL(1)) dutJ (
    .pixelClockXn(clk), .nReset(nReset), .pixelClockRef(refJ), .trackEnable(trackEnable),
    .phaseSelect(phaseSelect), .pixelClockX1_en(enJ), .currentPhase(phJ),
    .locked(lockJ), .slipCount(slipJ)
  );

  // Tracks the spacing between consecutive enable pulses of the main instance.
  always @(posedge clk) begin
    if (enA) begin
      if (sinceEn < 3) gapBad <= 1'b1;
      sinceEn <= 1;
    end else if (sinceEn < 100) begin
      sinceEn <= sinceEn + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic refPeriod();
    refA = 1'b1;
    repeat (3) tick();
    refA = 1'b0;
    repeat (3) tick();
  endtask

  task automatic waitPhase(input logic [2:0] p, input bit useJ);
    int n = 0;
    while (((useJ ? phJ : phA) != p) && (n < 12)) begin
      tick();
      n++;
    end
    chk("wait_phase", 32'(useJ ? phJ : phA), 32'(p));
  endtask

  initial begin
    nReset = 1'b0; refA = 1'b0; refJ = 1'b0; trackEnable = 1'b1; phaseSelect = 3'd3;
    repeat (3) tick();
    chk("rst_phase", 32'(phA), 0);
    chk("rst_en", 32'(enA), 0);
    chk("rst_locked", 32'(lockA), 0);
    chk("rst_slip", 32'(slipA), 0);
    chk("rst_phaseJ", 32'(phJ), 0);
    nReset = 1'b1;

    // free-running divide by 6, pulse one clock after phase 3
    for (int k = 1; k <= 24; k++) begin
      tick();
      chk("free_phase", 32'(phA), k % 6);
      chk("free_en", 32'(enA), int'(k % 6 == 4));
    end
    chk("free_locked", 32'(lockA), 0);
    chk("free_slip", 32'(slipA), 0);

    // aligned reference: refRise meets phase 0
    waitPhase(3'd4, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      refPeriod();
      chk("lock_aligned", 32'(lockA), int'(i == 16));
    end
    chk("aligned_slip", 32'(slipA), 0);
    chk("aligned_phase", 32'(phA), 4);

    // reference shifted by +2 clocks
    repeat (2) tick();
    refPeriod();
    chk("shift_slip", 32'(slipA), 1);
    chk("shift_locked", 32'(lockA), 0);
    chk("shift_phase", 32'(phA), 4);
    for (int i = 1; i <= 16; i++) begin
      refPeriod();
      chk("relock", 32'(lockA), int'(i == 16));
    end
    chk("relock_spacing", 32'(gapBad), 0);

    // reference stops: lock drops 24 clocks after the last edge is taken
    for (int k = 1; k <= 21; k++) begin
      tick();
      chk("loss_en", 32'(enA), int'((4 + k) % 6 == 4));
      if (k == 20) chk("loss_still_locked", 32'(lockA), 1);
      if (k == 21) chk("loss_unlocked", 32'(lockA), 0);
    end

    // phaseSelect beyond RATIO-1 clamps to 5
    phaseSelect = 3'd7;
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk("clamp_en", 32'(enA), int'((1 + t) % 6 == 0));
    end
    chk("clamp_phase", 32'(phA), 1);

    // spacing guard after a phase change and after a slip onto the compare phase
    phaseSelect = 3'd1;
    tick();
    chk("guard_psel_en", 32'(enA), 0);
    repeat (3) tick();
    refA = 1'b1;
    repeat (3) tick();
    chk("slip_fire_en", 32'(enA), 1);
    chk("slip_fire_phase", 32'(phA), 1);
    chk("slip_fire_count", 32'(slipA), 2);
    refA = 1'b0;
    tick();
    chk("guard_slip_en", 32'(enA), 0);
    chk("guard_slip_phase", 32'(phA), 2);
    repeat (6) tick();
    chk("guard_next_en", 32'(enA), 1);

    // jitter tolerance 1: edges alternate at phase 5 and phase 1
    waitPhase(3'd3, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      refJ = 1'b1;
      repeat (3) tick();
      refJ = 1'b0;
      repeat ((i % 2 == 1) ? 5 : 1) tick();
      chk("jitter_lock", 32'(lockJ), int'(i == 16));
    end
    chk("jitter_slip", 32'(slipJ), 0);

    // one-clock reset while dutJ is locked
    chk("pre_rst_slip", 32'(slipA), 2);
    nReset = 1'b0;
    tick();
    chk("mid_rst_phase", 32'(phA), 0);
    chk("mid_rst_en", 32'(enA), 0);
    chk("mid_rst_locked", 32'(lockA), 0);
    chk("mid_rst_slip", 32'(slipA), 0);
    chk("mid_rst_lockedJ", 32'(lockJ), 0);
    chk("mid_rst_phaseJ", 32'(phJ), 0);
    nReset = 1'b1;

    // period-5 reference forces a slip on every edge
    for (int p = 1; p <= 300; p++) begin
      refA = 1'b1;
      repeat (3) tick();
      refA = 1'b0;
      repeat (2) tick();
      if (p == 10) chk("slip_count_10", 32'(slipA), 10);
    end
    chk("slip_saturate", 32'(slipA), 255);
    chk("final_spacing", 32'(gapBad), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
